// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-cycle bus master.
//
// Converts a valid/ready request port into one Wishbone read or write cycle
// at a time and returns the read data, or a timeout error, on a valid/ready
// response port. Only one bus cycle is ever outstanding.
//
// Ports:
//   wb_clk_i, wb_reset_n_i     clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_we_i, req_adr_i,       request: direction, address, write data,
//   req_dat_i, req_sel_i       byte selects
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_dat_o, rsp_err_o       read data (0 for writes/errors), timeout flag
//   wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o  bus outputs
//   wb_dat_i, wb_ack_i         bus inputs
//
// Parameters: AW address width, DW data width (multiple of 8), TIMEOUT ack
// wait limit in cycles (0 = wait forever), TW timeout counter width.
module wb_initiator #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_adr_i,
  input  logic [DW-1:0]   req_dat_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i
);

  localparam int SW = DW / 8;
  // Last counter value before abort; only meaningful when TIMEOUT != 0.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  // cyc and stb are always equal for single classic cycles; one flop drives both.
  logic            cyc_q, cyc_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // req_ready_q is always high here, so valid alone means accepted.
        if (req_valid_i) begin
          adr_d       = req_adr_i;
          dat_d       = req_dat_i;
          we_d        = req_we_i;
          sel_d       = req_sel_i;
          cyc_d       = 1'b1;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          state_d     = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        // Staying here at least one cycle guarantees an stb-low gap.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      cyc_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: randomized self-checking bench for wb_initiator.
// A small misc-style slave (8 word registers, word 4 is a read-only
// sign-extended 12-bit audio sample) acks one cycle after each stb rise.
// A transaction-level reference model predicts response data, error flag,
// latency, strobe length and slave register contents.
module tb_wb_initiator;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 16;
  localparam int TW      = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_adr = '0;
  logic [DW-1:0]   req_dat = '0;
  logic [SW-1:0]   req_sel = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [DW-1:0]   rsp_dat;
  logic            rsp_err;
  logic [AW-1:0]   wb_adr;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_we;
  logic [SW-1:0]   wb_sel;
  logic            wb_cyc;
  logic            wb_stb;
  logic            wb_ack;

  always #5 clk = ~clk;

  wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .wb_clk_i    (clk),
    .wb_reset_n_i(rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_adr_i   (req_adr),
    .req_dat_i   (req_dat),
    .req_sel_i   (req_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we),
    .wb_sel_o    (wb_sel),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_ack_i    (wb_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic          slv_ack_en = 1'b1;
  logic          slv_ack = 1'b0;
  logic          spur_ack = 1'b0;
  logic          stb_prev = 1'b0;
  logic [DW-1:0] slv_mem [8];
  logic [DW-1:0] slv_rdat = '0;
  logic [11:0]   audio = 12'h800;
  int            slv_acks = 0;
  int            stb_rises = 0;

  assign wb_ack   = slv_ack | spur_ack;
  assign wb_dat_i = slv_rdat;

  always @(posedge clk) begin
    stb_prev <= wb_stb;
    slv_ack  <= 1'b0;
    if (wb_stb && !stb_prev) begin
      stb_rises <= stb_rises + 1;
      if (slv_ack_en) begin
        slv_ack  <= 1'b1;
        slv_acks <= slv_acks + 1;
        if (wb_we) begin
          if (wb_adr[2:0] != 3'd4)
            for (int b = 0; b < SW; b++)
              if (wb_sel[b]) slv_mem[wb_adr[2:0]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end else begin
          slv_rdat <= (wb_adr[2:0] == 3'd4) ? {{(DW-12){audio[11]}}, audio}
                                            : slv_mem[wb_adr[2:0]];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [8];
  int            exp_rises = 0;
  int            exp_acks = 0;

  function automatic logic [DW-1:0] ref_read(input logic [2:0] a);
    int s;
    if (a == 3'd4) begin
      s = $signed(audio);   // sign-extends the 12-bit sample
      return DW'(s);
    end
    return ref_mem[a];
  endfunction

  task automatic ref_write(input logic [2:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (a != 3'd4)
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // One full transaction; entered and left at a falling edge.
  task automatic do_txn(input bit we, input logic [2:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input bit ack_en, input int hold);
    logic [DW-1:0] exp_dat;
    bit            exp_err;
    int            w, lat, stb_cnt;
    exp_err = !ack_en;
    exp_dat = (ack_en && !we) ? ref_read(a) : '0;
    slv_ack_en = ack_en;
    rsp_ready  = (hold == 0);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_ready_wait", 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = AW'(a);
    req_dat   = d;
    req_sel   = s;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    stb_cnt = 0;
    while (!rsp_valid && lat < 100) begin
      if (wb_stb) begin
        stb_cnt++;
        check("bus_adr", 64'(wb_adr), 64'(a));
        check("bus_we", 64'(wb_we), 64'(we));
        check("bus_sel", 64'(wb_sel), 64'(s));
        if (we) check("bus_dat", 64'(wb_dat_o), 64'(d));
      end
      check("cyc_eq_stb", 64'(wb_cyc), 64'(wb_stb));
      check("req_ready_busy", 64'(req_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 64'(lat), ack_en ? 64'd3 : 64'(TIMEOUT + 1));
    check("stb_cycles", 64'(stb_cnt), ack_en ? 64'd2 : 64'(TIMEOUT));
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_dat", 64'(rsp_dat), 64'(exp_dat));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("stb_in_resp", 64'(wb_stb), 64'd0);
    for (int i = 0; i < hold; i++) begin
      spur_ack = (i == 1);
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_dat", 64'(rsp_dat), 64'(exp_dat));
      check("hold_err", 64'(rsp_err), 64'(exp_err));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_stb", 64'(wb_stb), 64'd0);
    end
    spur_ack  = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
    exp_rises++;
    if (ack_en) begin
      exp_acks++;
      if (we) ref_write(a, d, s);
    end
  endtask

  initial begin
    logic [DW-1:0] rv;
    for (int i = 0; i < 8; i++) begin
      rv = DW'($urandom);
      slv_mem[i] = rv;
      ref_mem[i] = rv;
    end
    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rst_cyc", 64'(wb_cyc), 64'd0);
    check("rst_stb", 64'(wb_stb), 64'd0);
    check("rst_we", 64'(wb_we), 64'd0);
    check("rst_adr", 64'(wb_adr), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    check("rst_sel", 64'(wb_sel), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write, read of audio, timeout, backpressure
    do_txn(1'b1, 3'd1, 32'h0000_00A5, 4'hF, 1'b1, 0);
    check("slave_intensity1", 64'(slv_mem[1]), 64'h0000_00A5);
    do_txn(1'b0, 3'd4, 32'h0, 4'hF, 1'b1, 0);
    do_txn(1'b0, 3'd2, 32'h0, 4'hF, 1'b0, 0);
    do_txn(1'b0, 3'd1, 32'h0, 4'hF, 1'b1, 0);
    do_txn(1'b0, 3'd1, 32'h0, 4'hF, 1'b1, 5);
    do_txn(1'b1, 3'd3, 32'h1234_5678, 4'hF, 1'b1, 0);
    do_txn(1'b1, 3'd5, 32'hCAFE_F00D, 4'hF, 1'b1, 0);

    // Spurious ack while idle
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    check("spur_idle_valid", 64'(rsp_valid), 64'd0);
    check("spur_idle_ready", 64'(req_ready), 64'd1);
    check("spur_idle_stb", 64'(wb_stb), 64'd0);
    @(negedge clk);
    check("spur_idle_valid2", 64'(rsp_valid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      do_txn(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), DW'($urandom),
             SW'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    // Reset in the middle of a bus cycle
    slv_ack_en = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = 32'h2;
    req_dat   = 32'hDEAD_BEEF;
    req_sel   = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_stb", 64'(wb_stb), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_cyc", 64'(wb_cyc), 64'd0);
    check("midrst_stb", 64'(wb_stb), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rises++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_valid", 64'(rsp_valid), 64'd0);
      check("postrst_stb", 64'(wb_stb), 64'd0);
      check("postrst_ready", 64'(req_ready), 64'd1);
    end
    do_txn(1'b0, 3'd2, 32'h0, 4'hF, 1'b1, 0);

    // Totals and slave register contents
    check("stb_rises", 64'(stb_rises), 64'(exp_rises));
    check("slave_acks", 64'(slv_acks), 64'(exp_acks));
    for (int i = 0; i < 8; i++) check("slave_mem", 64'(slv_mem[i]), 64'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic single-cycle bus master for the badge SoC.
- Turns a simple valid/ready request port into one Wishbone read or write cycle at a time, and returns read data or an error on a valid/ready response port.
- Sits between an internal sequencer (boot loader, animation engine or debug bridge) and the shared Wishbone fabric, which hosts the misc LED/button/audio peripheral and others.
- Slaves in the fabric detect the rising edge of stb and ack one cycle later. The initiator must therefore deassert cyc/stb for at least one cycle between cycles.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 16, cycles to wait for ack before aborting; 0 = wait forever
TW, 8, timeout counter width; must hold TIMEOUT

Ports:
wb_clk_i  in  1  clock
wb_reset_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid&&ready
req_we_i  in  1  1=write, 0=read
req_adr_i  in  AW  address
req_dat_i  in  DW  write data
req_sel_i  in  DW/8  byte selects
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_dat_o  out  DW  read data (0 for writes/errors)
rsp_err_o  out  1  cycle timed out
wb_adr_o  out  AW  bus address
wb_dat_o  out  DW  bus write data
wb_dat_i  in  DW  bus read data
wb_we_o  out  1  bus write enable
wb_sel_o  out  DW/8  bus byte selects
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_ack_i  in  1  bus acknowledge

Behaviour:
- Clocking: one clock, wb_clk_i. Reset is asynchronous and active-low (wb_reset_n_i). All state and outputs are registered.
- Reset (wb_reset_n_i=0) forces, asynchronously:
  - state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_dat_o=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0; wb_adr_o, wb_dat_o, wb_sel_o = 0; timeout counter=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch we/adr/dat/sel into the wb_* output registers, set cyc=stb=1, clear counter, go to BUS, and drop req_ready_o.
  - Bus outputs become visible in the cycle after acceptance.
- BUS:
  - cyc/stb held high; adr/dat/we/sel are stable for the whole cycle.
  - wb_ack_i=1:
    - cyc=stb=0.
    - rsp_dat_o=wb_dat_i for reads, 0 for writes.
    - rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - No ack and TIMEOUT!=0: counter increments each BUS cycle. When counter==TIMEOUT-1 and there is still no ack:
    - cyc=stb=0; rsp_dat_o=0; rsp_err_o=1; rsp_valid_o=1; go to RESP.
  - If ack and the timeout fall in the same cycle, ack wins (success).
- RESP:
  - cyc=stb=0; rsp_* outputs held stable.
  - On rsp_ready_i: rsp_valid_o=0, rsp_err_o=0, req_ready_o=1, go to IDLE.
  - RESP therefore guarantees at least one cycle with stb low between consecutive bus cycles, even with rsp_ready_i tied high.
- wb_ack_i outside BUS is ignored. Requests are never accepted outside IDLE.
- Latency with a fabric slave that acks one cycle after stb rises:
  - Accept edge N; stb high in cycles N+1..N+2; ack sampled at N+2; rsp_valid_o high in N+3.
  - With rsp_ready_i=1, the next acceptance is possible at edge N+4 (IDLE in cycle N+4).
- Reset mid-cycle drops cyc/stb immediately. Any pending response is discarded, not retried.

Test Plan:
- Write: with the misc slave model attached, req(we=1, adr=0x1, dat=0x000000A5, sel=0xF) -> one cyc/stb pulse of 2 cycles with adr=0x1, dat=0xA5, we=1; then rsp_valid=1, rsp_err=0, rsp_dat=0; slave intensity[1]=0xA5.
- Read: req(we=0, adr=0x4) with slave audio=0x800 -> rsp_dat=0xFFFFF800, rsp_err=0, rsp_valid 3 cycles after acceptance.
- Timeout: TIMEOUT=16, wb_ack_i tied 0 -> stb high exactly 16 cycles, then stb=0, rsp_valid=1, rsp_err=1, rsp_dat=0; the next request proceeds normally.
- Backpressure and gap: rsp_ready low for 5 cycles -> rsp_valid and rsp_dat stable, req_ready=0, stb=0. With rsp_ready=1 and continuous req_valid, two back-to-back writes show at least one stb-low cycle between them, and each produces exactly one slave ack.
- Reset mid-cycle: assert wb_reset_n_i=0 while stb=1 -> cyc/stb/rsp_valid go low asynchronously in the same cycle; after release req_ready=1 and no stale response appears.
- Spurious ack: pulse wb_ack_i in IDLE and RESP -> no state change, no extra response.
